// File: rtl/s_mux_rr.sv
// Registered N-channel data selector with per-channel valid/ready handshakes.
// Selection is either direct (S_Sel) or round-robin across the valid channels.
module s_mux_rr #(
  parameter int WIDTH    = 64,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [CHANNELS*WIDTH-1:0] d_in,
  input  logic [CHANNELS-1:0]       d_valid,
  output logic [CHANNELS-1:0]       d_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          S_Sel,
  output logic [WIDTH-1:0]          S_mux_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      sel_err,
  input  logic                      err_clr
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] chan_q, chan_d;
  logic             err_q, err_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

  logic             load_en_s;
  logic             sel_ok_s;
  logic             dir_hit_s;
  logic             rr_hit_s;
  logic [SEL_W-1:0] rr_idx_s;
  int               rr_best_s;
  int               rr_dist_s;
  logic             grant_s;
  logic [SEL_W-1:0] grant_idx_s;

  // Grant decision for both modes and the resulting channel accept vector.
  always_comb begin
    load_en_s   = !valid_q || out_ready;
    sel_ok_s    = (int'(S_Sel) < CHANNELS);
    dir_hit_s   = 1'b0;
    rr_hit_s    = 1'b0;
    rr_idx_s    = '0;
    rr_best_s   = CHANNELS;
    rr_dist_s   = 0;
    grant_s     = 1'b0;
    grant_idx_s = '0;
    d_ready     = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (int'(S_Sel) == i && d_valid[i]) begin
        dir_hit_s = 1'b1;
      end else begin
        dir_hit_s = dir_hit_s;
      end
      // Distance 0 is the channel right after the last grant; the last grant is searched last.
      rr_dist_s = (i + CHANNELS - 1 - int'(rr_ptr_q)) % CHANNELS;
      if (d_valid[i] && rr_dist_s < rr_best_s) begin
        rr_best_s = rr_dist_s;
        rr_idx_s  = SEL_W'(i);
        rr_hit_s  = 1'b1;
      end else begin
        rr_best_s = rr_best_s;
      end
    end
    if (mode) begin
      grant_s     = rr_hit_s && load_en_s;
      grant_idx_s = rr_idx_s;
    end else begin
      grant_s     = sel_ok_s && dir_hit_s && load_en_s;
      grant_idx_s = S_Sel;
    end
    for (int i = 0; i < CHANNELS; i++) begin
      d_ready[i] = grant_s && (int'(grant_idx_s) == i);
    end
  end

  // Next-state for the output register, round-robin pointer and sticky error.
  always_comb begin
    data_d   = data_q;
    chan_d   = chan_q;
    valid_d  = valid_q;
    rr_ptr_d = rr_ptr_q;
    err_d    = err_q;
    if (grant_s) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (int'(grant_idx_s) == i) begin
          data_d = d_in[i*WIDTH +: WIDTH];
        end else begin
          data_d = data_d;
        end
      end
      chan_d  = grant_idx_s;
      valid_d = 1'b1;
      if (mode) begin
        rr_ptr_d = grant_idx_s;
      end else begin
        rr_ptr_d = rr_ptr_q;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    if (!mode && !sel_ok_s) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q   <= '0;
      valid_q  <= 1'b0;
      chan_q   <= '0;
      err_q    <= 1'b0;
      rr_ptr_q <= LAST_CH;
    end else begin
      data_q   <= data_d;
      valid_q  <= valid_d;
      chan_q   <= chan_d;
      err_q    <= err_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign S_mux_out = data_q;
  assign out_valid = valid_q;
  assign out_chan  = chan_q;
  assign sel_err   = err_q;

endmodule

// File: tb/tb_s_mux_rr.sv
// Directed bench for s_mux_rr: a 4-channel instance for the main paths and a
// 3-channel instance for out-of-range direct selects.
module tb_s_mux_rr;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // 4-channel instance
  logic [63:0] a_d_in;
  logic [3:0]  a_d_valid, a_d_ready;
  logic        a_mode, a_out_valid, a_out_ready, a_sel_err, a_err_clr;
  logic [1:0]  a_sel, a_out_chan;
  logic [15:0] a_out;

  // 3-channel instance
  logic [47:0] b_d_in;
  logic [2:0]  b_d_valid, b_d_ready;
  logic        b_mode, b_out_valid, b_out_ready, b_sel_err, b_err_clr;
  logic [1:0]  b_sel, b_out_chan;
  logic [15:0] b_out;

  int n_checks = 0;
  int n_fail = 0;

  s_mux_rr #(.WIDTH(16), .CHANNELS(4), .SEL_W(2)) u4 (
    .clk(clk), .reset_n(reset_n), .d_in(a_d_in), .d_valid(a_d_valid), .d_ready(a_d_ready),
    .mode(a_mode), .S_Sel(a_sel), .S_mux_out(a_out), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_chan(a_out_chan), .sel_err(a_sel_err), .err_clr(a_err_clr)
  );

  s_mux_rr #(.WIDTH(16), .CHANNELS(3), .SEL_W(2)) u3 (
    .clk(clk), .reset_n(reset_n), .d_in(b_d_in), .d_valid(b_d_valid), .d_ready(b_d_ready),
    .mode(b_mode), .S_Sel(b_sel), .S_mux_out(b_out), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_chan(b_out_chan), .sel_err(b_sel_err), .err_clr(b_err_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    a_d_in = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
    a_d_valid = 4'b0000; a_mode = 1'b0; a_sel = 2'd0; a_out_ready = 1'b1; a_err_clr = 1'b0;
    b_d_in = 48'h0; b_d_valid = 3'b000; b_mode = 1'b0; b_sel = 2'd0; b_out_ready = 1'b1; b_err_clr = 1'b0;
    reset_n = 1'b0;
    tick();
    n_checks++;
    if (a_out !== 16'h0 || a_out_valid !== 1'b0 || a_out_chan !== 2'd0 || a_sel_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_u4: out=%h valid=%b chan=%0d err=%b, expected 0 0 0 0", a_out, a_out_valid, a_out_chan, a_sel_err);
    end
    n_checks++;
    if (b_out !== 16'h0 || b_out_valid !== 1'b0 || b_sel_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_u3: out=%h valid=%b err=%b, expected 0 0 0", b_out, b_out_valid, b_sel_err);
    end
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_direct();
    a_mode = 1'b0; a_sel = 2'd2; a_out_ready = 1'b1;
    a_d_in = {16'h1003, 16'hA5A5, 16'h1001, 16'h1000};
    a_d_valid = 4'b0100;
    #1;
    n_checks++;
    if (a_d_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL direct_ready: got %b expected 0100", a_d_ready);
    end
    tick();
    a_d_valid = 4'b0000;
    n_checks++;
    if (a_out !== 16'hA5A5 || a_out_chan !== 2'd2 || a_out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL direct_capture: out=%h chan=%0d valid=%b, expected a5a5 2 1", a_out, a_out_chan, a_out_valid);
    end
    tick();
    n_checks++;
    if (a_out_valid !== 1'b0 || a_out !== 16'hA5A5) begin
      n_fail++;
      $display("FAIL direct_drain: valid=%b out=%h, expected 0 a5a5", a_out_valid, a_out);
    end
  endtask

  task automatic test_invalid_sel();
    b_mode = 1'b0; b_out_ready = 1'b1; b_sel = 2'd1;
    b_d_in = {16'h2222, 16'h1111, 16'h0000};
    b_d_valid = 3'b111;
    tick();
    b_sel = 2'd3;
    #1;
    n_checks++;
    if (b_d_ready !== 3'b000) begin
      n_fail++;
      $display("FAIL invalid_ready: got %b expected 000", b_d_ready);
    end
    tick();
    n_checks++;
    if (b_sel_err !== 1'b1 || b_out !== 16'h1111 || b_out_valid !== 1'b0 || b_out_chan !== 2'd1) begin
      n_fail++;
      $display("FAIL invalid_err: err=%b out=%h valid=%b chan=%0d, expected 1 1111 0 1", b_sel_err, b_out, b_out_valid, b_out_chan);
    end
    b_err_clr = 1'b1;
    tick();
    n_checks++;
    if (b_sel_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_set_priority: err=%b expected 1", b_sel_err);
    end
    b_sel = 2'd0; b_d_valid = 3'b000;
    tick();
    b_err_clr = 1'b0;
    n_checks++;
    if (b_sel_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: err=%b expected 0", b_sel_err);
    end
  endtask

  task automatic test_rr_all();
    logic [1:0] exp_ch [6];
    logic [3:0] exp_rdy;
    logic [15:0] exp_dat;
    exp_ch = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    a_d_in = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
    a_d_valid = 4'b0000; a_mode = 1'b1; a_out_ready = 1'b1;
    do_reset();
    a_d_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      #1;
      exp_rdy = 4'b0001 << exp_ch[i];
      n_checks++;
      if (a_d_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL rr_all_ready[%0d]: got %b expected %b", i, a_d_ready, exp_rdy);
      end
      tick();
      exp_dat = 16'h1000 + {14'd0, exp_ch[i]};
      n_checks++;
      if (a_out_chan !== exp_ch[i] || a_out !== exp_dat || a_out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL rr_all_out[%0d]: chan=%0d out=%h valid=%b expected %0d %h 1", i, a_out_chan, a_out, a_out_valid, exp_ch[i], exp_dat);
      end
    end
    a_d_valid = 4'b0000;
  endtask

  task automatic test_rr_sparse();
    logic [1:0] exp_ch [4];
    exp_ch = '{2'd1, 2'd3, 2'd1, 2'd3};
    do_reset();
    a_mode = 1'b1; a_out_ready = 1'b1;
    a_d_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (a_d_ready !== (4'b0001 << exp_ch[i])) begin
        n_fail++;
        $display("FAIL rr_sparse_ready[%0d]: got %b expected channel %0d", i, a_d_ready, exp_ch[i]);
      end
      tick();
      n_checks++;
      if (a_out_chan !== exp_ch[i]) begin
        n_fail++;
        $display("FAIL rr_sparse_chan[%0d]: got %0d expected %0d", i, a_out_chan, exp_ch[i]);
      end
    end
    a_d_valid = 4'b0000;
  endtask

  task automatic test_back_to_back();
    do_reset();
    a_mode = 1'b1; a_out_ready = 1'b1;
    a_d_valid = 4'b0001;
    tick();
    a_out_ready = 1'b0;
    a_d_valid = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (a_d_ready !== 4'b0000) begin
        n_fail++;
        $display("FAIL bp_ready[%0d]: got %b expected 0000", i, a_d_ready);
      end
      tick();
      n_checks++;
      if (a_out !== 16'h1000 || a_out_valid !== 1'b1 || a_out_chan !== 2'd0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: out=%h valid=%b chan=%0d expected 1000 1 0", i, a_out, a_out_valid, a_out_chan);
      end
    end
    a_out_ready = 1'b1;
    #1;
    n_checks++;
    if (a_d_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL drain_load_ready: got %b expected 0010", a_d_ready);
    end
    tick();
    n_checks++;
    if (a_out !== 16'h1001 || a_out_valid !== 1'b1 || a_out_chan !== 2'd1) begin
      n_fail++;
      $display("FAIL drain_load: out=%h valid=%b chan=%0d expected 1001 1 1", a_out, a_out_valid, a_out_chan);
    end
  endtask

  task automatic test_reset_midstream();
    // out_valid is 1 and all channels are still requesting here.
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (a_out !== 16'h0 || a_out_valid !== 1'b0 || a_out_chan !== 2'd0 || a_sel_err !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: out=%h valid=%b chan=%0d err=%b expected 0 0 0 0", a_out, a_out_valid, a_out_chan, a_sel_err);
    end
    tick();
    n_checks++;
    if (a_out_valid !== 1'b0 || a_out !== 16'h0) begin
      n_fail++;
      $display("FAIL mid_reset_hold: valid=%b out=%h expected 0 0", a_out_valid, a_out);
    end
    reset_n = 1'b1;
    #1;
    n_checks++;
    if (a_d_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL post_reset_ready: got %b expected 0001", a_d_ready);
    end
    tick();
    n_checks++;
    if (a_out_chan !== 2'd0 || a_out !== 16'h1000 || a_out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_grant: chan=%0d out=%h valid=%b expected 0 1000 1", a_out_chan, a_out, a_out_valid);
    end
    a_d_valid = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_direct();
    test_invalid_sel();
    test_rr_all();
    test_rr_sparse();
    test_back_to_back();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
